// File: rtl/hf_bypass_chain.sv
// Chain of DEPTH bypassable register stages with a drain-then-apply
// reconfiguration sequencer, so pipeline depth can be swept at run time.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | accepting input; cfg_load captures mask and starts a drain
// S_DRAIN | input blocked, bubbles flush in-flight samples (latency+1)
// S_APPLY | one cycle: new mask/latency take effect, stage valids cleared
module hf_bypass_chain #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DEPTH-1:0] cfg_mask,
  input  logic             cfg_load,
  output logic             cfg_busy,
  output logic [DEPTH-1:0] active_mask,
  output logic [LW-1:0]    latency,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_APPLY} state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [DEPTH-1:0]              r_mask;
  logic [DEPTH-1:0]              r_pend;
  logic [LW-1:0]                 r_lat;
  logic [LW-1:0]                 r_cnt;
  logic [DEPTH-1:0][WIDTH-1:0]   r_data;
  logic [DEPTH-1:0]              r_vld;
  logic [DEPTH-1:0][WIDTH-1:0]   w_stg_data;
  logic [DEPTH-1:0]              w_stg_vld;
  logic [WIDTH-1:0]              w_chain_data;
  logic                          w_chain_vld;
  logic                          w_ready;
  logic                          w_load;
  logic                          w_apply;

  function automatic logic [LW-1:0] popcnt(input logic [DEPTH-1:0] m);
    logic [LW-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + LW'(m[i]);
    return c;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_load      = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (cfg_load) begin
          w_load      = 1'b1;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_cnt == '0) w_state_nxt = S_APPLY;
      end
      S_APPLY: begin
        w_apply     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_pend <= cfg_mask;
        r_cnt  <= r_lat;
      end else if (r_state == S_DRAIN && r_cnt != '0) begin
        r_cnt <= r_cnt - LW'(1);
      end
      if (w_apply) begin
        r_mask <= r_pend;
        r_lat  <= popcnt(r_pend);
      end
    end
  end

  // Walk the chain: each stage sees the previous stage's output and either
  // forwards its register or passes the input straight through.
  always_comb begin
    w_stg_data   = '0;
    w_stg_vld    = '0;
    w_chain_data = in_data;
    w_chain_vld  = in_valid & w_ready;
    for (int i = 0; i < DEPTH; i++) begin
      w_stg_data[i] = w_chain_data;
      w_stg_vld[i]  = w_chain_vld;
      if (r_mask[i]) begin
        w_chain_data = r_data[i];
        w_chain_vld  = r_vld[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_vld  <= '0;
    end else begin
      r_data <= w_stg_data;
      r_vld  <= w_apply ? '0 : w_stg_vld;
    end
  end

  assign in_ready    = w_ready;
  assign cfg_busy    = (r_state != S_IDLE);
  assign active_mask = r_mask;
  assign latency     = r_lat;
  assign out_data    = w_chain_data;
  assign out_valid   = w_chain_vld;

endmodule

// File: doc/hf_bypass_chain.md
Name: hf_bypass_chain

Overview:
- Parametrised successor to the single bypassable HyperFlex register: a chain of DEPTH bypassable register stages carrying WIDTH-bit data plus a valid bit.
- Each stage's bypass is selected by a run-time mask.
- Reconfiguring the mask is safe: a drain state machine blocks new input, flushes in-flight samples, then applies the new mask.
- Used to sweep pipeline depth on retiming-sensitive datapaths without resynthesis.

Parameters:
WIDTH, 8, data bits per sample
DEPTH, 4, number of bypassable stages (>=1)
LW, $clog2(DEPTH+1), width of latency/count fields (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_data  in  WIDTH  sample into stage 0
in_valid  in  1  sample qualifier
in_ready  out  1  high when the chain accepts input (state IDLE)
cfg_mask  in  DEPTH  requested mask; bit i=1 registers stage i, 0 bypasses it
cfg_load  in  1  request to apply cfg_mask
cfg_busy  out  1  high while reconfiguring (state != IDLE)
active_mask  out  DEPTH  mask currently in force
latency  out  LW  popcount(active_mask), registered
out_data  out  WIDTH  chain output
out_valid  out  1  output qualifier

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - active_mask=0 (full bypass), latency=0.
  - All stage data registers 0, all stage valid registers 0.
  - state=IDLE, so in_ready=1 and cfg_busy=0.
  - Drain counter 0, pending mask 0.
- Stage i (0..DEPTH-1):
  - Input is stage i-1's output; stage 0 input is (in_data, in_valid & in_ready).
  - Data and valid registers capture the stage input every cycle.
  - Output is the registered pair if active_mask[i]=1, else the stage input (combinational).
- Output: out_data/out_valid = stage DEPTH-1 output.
  - Latency from accepted input to out_valid is exactly `latency` cycles.
  - latency=0 is a fully combinational path.
  - Data is don't-care when valid=0, but the bench checks data only when valid=1.
- Input: in_valid while in_ready=0 is dropped, never queued. No output backpressure.
- FSM states:
  - IDLE: in_ready=1. cfg_load=1 captures cfg_mask into the pending register, loads the drain counter with the current latency, and goes to DRAIN.
  - DRAIN: in_ready=0, so zero-valid bubbles enter the chain. If the counter is 0, go to APPLY; otherwise decrement and stay. DRAIN lasts latency+1 cycles.
  - APPLY: one cycle. At its closing edge: active_mask <= pending, latency <= popcount(pending), all stage valid registers cleared. Then IDLE.
- Reconfiguration timing: if cfg_load is sampled at edge T with latency L:
  - The last accepted sample is the one presented in cycle T.
  - That sample appears at the output in cycle T+L, before the mask changes.
  - cfg_busy is high for L+2 cycles.
  - in_ready returns in cycle T+L+3.
- cfg_load while busy is ignored; it is not queued.
- cfg_load with a mask equal to active_mask still runs the full sequence.
- Simultaneous in_valid and cfg_load in IDLE: the sample is accepted and drained under the old mask.
- No sample is ever lost, duplicated or reordered across reconfiguration.
- Reset mid-DRAIN/APPLY: immediate return to IDLE with the reset values above. The pending mask is discarded.

Test Plan:
- Reset then bypass: rst_n low→high; in_data=0xA5, in_valid=1 in the same cycle → out_data=0xA5, out_valid=1 in that cycle; latency=0, in_ready=1.
- Full pipeline: cfg_mask=4'b1111 + cfg_load → cfg_busy high 2 cycles (L=0), then latency=4. Stream 0x01..0x08 back-to-back → outputs 0x01..0x08, each exactly 4 cycles after input, no gaps.
- Partial mask: from 4'b1111, load 4'b0101 while streaming 0x10..0x1F.
  - All samples accepted up to and including the cfg_load cycle emerge in order, 4 cycles after input.
  - in_ready stays low 6 cycles; samples offered then are dropped.
  - Afterwards latency=2 and new samples emerge 2 cycles after input.
- Busy-ignore: during DRAIN, pulse cfg_load with 4'b0000 → ignored; active_mask ends at the first requested value.
- Reset mid-drain: assert rst_n low in DRAIN from mask 4'b1111 → out_valid=0, active_mask=0, cfg_busy=0 immediately; the next accepted sample passes combinationally.
- Random soak: random masks and in_valid at 50% for 10k cycles; a scoreboard checks order, no loss of accepted samples, and per-sample latency equal to the latency value at acceptance.
